cpu_exec_units: RTL and testbench

CPU_EXEC_UNITS -- requirements
Module: cpu_exec_units

---
 rtl/cpu_exec_units_if.sv | 35 +++
 rtl/cpu_exec_units.sv | 145 ++++++++++++++
 tb/tb_cpu_exec_units.sv | 299 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_exec_units_if.sv
// Execution-unit bus: ALU, CSR file and load-data extender signals.
// The master drives operands and CSR requests; the slave returns results.
interface cpu_exec_units_if;
  logic [31:0] alu_src_a;
  logic [31:0] alu_src_b;
  logic [3:0]  alu_control;
  logic [31:0] alu_result;
  logic        alu_zero;
  logic        alu_lt;
  logic        alu_borrow;
  logic [11:0] csr_raddr;
  logic [31:0] csr_rdata;
  logic [11:0] csr_waddr;
  logic [31:0] csr_wdata;
  logic        csr_wenable;
  logic [31:0] ext_data;
  logic [2:0]  ext_control;
  logic [31:0] ext_data_out;

  modport master (
    output alu_src_a, alu_src_b, alu_control,
    output csr_raddr, csr_waddr, csr_wdata, csr_wenable,
    output ext_data, ext_control,
    input  alu_result, alu_zero, alu_lt, alu_borrow,
    input  csr_rdata, ext_data_out
  );

  modport slave (
    input  alu_src_a, alu_src_b, alu_control,
    input  csr_raddr, csr_waddr, csr_wdata, csr_wenable,
    input  ext_data, ext_control,
    output alu_result, alu_zero, alu_lt, alu_borrow,
    output csr_rdata, ext_data_out
  );
endinterface

// File: rtl/cpu_exec_units.sv
// RV32 execution units: combinational ALU and load extender,
// machine-mode CSR file with a free-running 64-bit cycle counter.
module cpu_exec_units #(
  parameter logic [31:0] MHARTID    = 32'h0,
  parameter logic [31:0] MISA_VALUE = 32'h40000100
) (
  input logic            clk,
  input logic            rst_n,
  cpu_exec_units_if.slave bus
);

  logic [31:0] w_a;
  logic [31:0] w_b;
  logic [4:0]  w_shamt;
  logic [32:0] w_diff;
  logic        w_lt;
  logic [31:0] w_result;

  assign w_a     = bus.alu_src_a;
  assign w_b     = bus.alu_src_b;
  assign w_shamt = w_b[4:0];
  assign w_diff  = {1'b0, w_a} - {1'b0, w_b};
  assign w_lt    = (w_a[31] != w_b[31]) ? w_a[31] : w_diff[31];

  // ALU operation select; unused codes yield zero
  always_comb begin
    w_result = 32'h0;
    case (bus.alu_control)
      4'b0000: w_result = w_a + w_b;
      4'b1000: w_result = w_diff[31:0];
      4'b0001: w_result = w_a << w_shamt;
      4'b0010: w_result = {31'h0, w_lt};
      4'b0011: w_result = {31'h0, w_diff[32]};
      4'b0100: w_result = w_a ^ w_b;
      4'b0101: w_result = w_a >> w_shamt;
      4'b1101: w_result = $signed(w_a) >>> w_shamt;
      4'b0110: w_result = w_a | w_b;
      4'b0111: w_result = w_a & w_b;
      4'b1001: w_result = w_b;
      4'b1010: w_result = w_a & ~w_b;
      default: w_result = 32'h0;
    endcase
  end

  assign bus.alu_result = w_result;
  assign bus.alu_zero   = (w_result == 32'h0);
  assign bus.alu_lt     = w_lt;
  assign bus.alu_borrow = w_diff[32];

  logic [31:0] w_ext;

  // Load data sign/zero extension by funct3
  always_comb begin
    w_ext = bus.ext_data;
    case (bus.ext_control)
      3'b000:  w_ext = {{24{bus.ext_data[7]}}, bus.ext_data[7:0]};
      3'b001:  w_ext = {{16{bus.ext_data[15]}}, bus.ext_data[15:0]};
      3'b100:  w_ext = {24'h0, bus.ext_data[7:0]};
      3'b101:  w_ext = {16'h0, bus.ext_data[15:0]};
      default: w_ext = bus.ext_data;
    endcase
  end

  assign bus.ext_data_out = w_ext;

  logic [31:0] r_mstatus;
  logic [31:0] r_mie;
  logic [31:0] r_mtvec;
  logic [31:0] r_mscratch;
  logic [31:0] r_mepc;
  logic [31:0] r_mcause;
  logic [31:0] r_mtval;
  logic [31:0] r_mip;
  logic [63:0] r_cycle;
  logic [63:0] w_cycle_inc;
  logic [63:0] w_cycle_nxt;

  assign w_cycle_inc = r_cycle + 64'd1;

  // Counter advances each cycle; a CSR write replaces only its half
  always_comb begin
    w_cycle_nxt = w_cycle_inc;
    if (bus.csr_wenable) begin
      if (bus.csr_waddr == 12'hB00)
        w_cycle_nxt[31:0] = bus.csr_wdata;
      if (bus.csr_waddr == 12'hB80)
        w_cycle_nxt[63:32] = bus.csr_wdata;
    end
  end

  // CSR state update; reset clears everything and masks writes
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_mstatus  <= 32'h0;
      r_mie      <= 32'h0;
      r_mtvec    <= 32'h0;
      r_mscratch <= 32'h0;
      r_mepc     <= 32'h0;
      r_mcause   <= 32'h0;
      r_mtval    <= 32'h0;
      r_mip      <= 32'h0;
      r_cycle    <= 64'h0;
    end else begin
      r_cycle <= w_cycle_nxt;
      if (bus.csr_wenable) begin
        case (bus.csr_waddr)
          12'h300: r_mstatus  <= bus.csr_wdata;
          12'h304: r_mie      <= bus.csr_wdata;
          12'h305: r_mtvec    <= bus.csr_wdata;
          12'h340: r_mscratch <= bus.csr_wdata;
          12'h341: r_mepc     <= {bus.csr_wdata[31:2], 2'b00};
          12'h342: r_mcause   <= bus.csr_wdata;
          12'h343: r_mtval    <= bus.csr_wdata;
          12'h344: r_mip      <= bus.csr_wdata;
          default: ;
        endcase
      end
    end
  end

  logic [31:0] w_rdata;

  // Combinational CSR read; unimplemented addresses read zero
  always_comb begin
    w_rdata = 32'h0;
    case (bus.csr_raddr)
      12'h300: w_rdata = r_mstatus;
      12'h301: w_rdata = MISA_VALUE;
      12'h304: w_rdata = r_mie;
      12'h305: w_rdata = r_mtvec;
      12'h340: w_rdata = r_mscratch;
      12'h341: w_rdata = r_mepc;
      12'h342: w_rdata = r_mcause;
      12'h343: w_rdata = r_mtval;
      12'h344: w_rdata = r_mip;
      12'hB00: w_rdata = r_cycle[31:0];
      12'hB80: w_rdata = r_cycle[63:32];
      12'hF14: w_rdata = MHARTID;
      default: w_rdata = 32'h0;
    endcase
  end

  assign bus.csr_rdata = w_rdata;

endmodule

// File: tb/tb_cpu_exec_units.sv
// Bench for cpu_exec_units: random stimulus against a behavioural
// model, plus directed literal checks of the documented examples.
module tb_cpu_exec_units;

  localparam logic [31:0] HART = 32'h0000_0005;
  localparam logic [31:0] MISA = 32'h4000_0100;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic chk_en = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  cpu_exec_units_if bus ();

  cpu_exec_units #(
    .MHARTID    (HART),
    .MISA_VALUE (MISA)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // model state
  logic [31:0] m_rw [0:7];
  logic [63:0] m_cyc;

  function automatic int rw_idx(input logic [11:0] ad);
    case (ad)
      12'h300: return 0;
      12'h304: return 1;
      12'h305: return 2;
      12'h340: return 3;
      12'h341: return 4;
      12'h342: return 5;
      12'h343: return 6;
      12'h344: return 7;
      default: return -1;
    endcase
  endfunction

  function automatic logic [31:0] csr_model(input logic [11:0] ad);
    int k;
    k = rw_idx(ad);
    if (k >= 0) return m_rw[k];
    if (ad == 12'h301) return MISA;
    if (ad == 12'hF14) return HART;
    if (ad == 12'hB00) return m_cyc[31:0];
    if (ad == 12'hB80) return m_cyc[63:32];
    return 32'h0;
  endfunction

  function automatic logic [31:0] alu_model(
    input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
    int unsigned sh;
    sh = b % 32;
    case (op)
      4'b0000: return a + b;
      4'b1000: return a - b;
      4'b0001: return a << sh;
      4'b0010: return ($signed(a) < $signed(b)) ? 32'h1 : 32'h0;
      4'b0011: return (a < b) ? 32'h1 : 32'h0;
      4'b0100: return a ^ b;
      4'b0101: return a >> sh;
      4'b1101: return 32'($signed(a) >>> sh);
      4'b0110: return a | b;
      4'b0111: return a & b;
      4'b1001: return b;
      4'b1010: return a & ~b;
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [31:0] ext_model(
    input logic [31:0] d, input logic [2:0] f);
    int v;
    case (f)
      3'b000: begin v = int'($signed(d[7:0]));  return 32'(v); end
      3'b001: begin v = int'($signed(d[15:0])); return 32'(v); end
      3'b100: return d & 32'h0000_00FF;
      3'b101: return d & 32'h0000_FFFF;
      default: return d;
    endcase
  endfunction

  // model CSR/counter update at each rising edge
  always @(posedge clk) begin
    logic [63:0] nc;
    int k;
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) m_rw[i] <= 32'h0;
      m_cyc <= 64'h0;
    end else begin
      nc = m_cyc + 64'd1;
      if (bus.csr_wenable) begin
        if (bus.csr_waddr == 12'hB00) nc[31:0]  = bus.csr_wdata;
        if (bus.csr_waddr == 12'hB80) nc[63:32] = bus.csr_wdata;
        k = rw_idx(bus.csr_waddr);
        if (k == 4)
          m_rw[k] <= bus.csr_wdata & 32'hFFFF_FFFC;
        else if (k >= 0)
          m_rw[k] <= bus.csr_wdata;
      end
      m_cyc <= nc;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // per-cycle comparison against the model
  always @(negedge clk) begin
    logic [31:0] r;
    if (chk_en) begin
      r = alu_model(bus.alu_src_a, bus.alu_src_b, bus.alu_control);
      chk("alu_result", bus.alu_result, r);
      chk("alu_zero", 32'(bus.alu_zero), 32'(r == 32'h0));
      chk("alu_lt", 32'(bus.alu_lt),
          32'($signed(bus.alu_src_a) < $signed(bus.alu_src_b)));
      chk("alu_borrow", 32'(bus.alu_borrow),
          32'(bus.alu_src_a < bus.alu_src_b));
      chk("csr_rdata", bus.csr_rdata, csr_model(bus.csr_raddr));
      chk("ext_data_out", bus.ext_data_out,
          ext_model(bus.ext_data, bus.ext_control));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic alu_set(input logic [31:0] a, input logic [31:0] b,
                         input logic [3:0] op);
    bus.alu_src_a   = a;
    bus.alu_src_b   = b;
    bus.alu_control = op;
  endtask

  task automatic csr_wr(input logic [11:0] ad, input logic [31:0] d);
    bus.csr_waddr   = ad;
    bus.csr_wdata   = d;
    bus.csr_wenable = 1'b1;
  endtask

  function automatic logic [31:0] rnd32();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'h7FFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'hFFFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  logic [11:0] addrs [0:14];

  initial begin
    addrs = '{12'h300, 12'h301, 12'h304, 12'h305, 12'h340, 12'h341,
              12'h342, 12'h343, 12'h344, 12'hB00, 12'hB80, 12'hF14,
              12'h7C0, 12'h000, 12'hFFF};
    alu_set(32'h0, 32'h0, 4'h0);
    bus.csr_raddr   = 12'h340;
    bus.csr_waddr   = 12'h0;
    bus.csr_wdata   = 32'h0;
    bus.csr_wenable = 1'b0;
    bus.ext_data    = 32'h0;
    bus.ext_control = 3'b000;
    rst_n = 1'b0;
    tick();
    tick();
    chk_en = 1'b1;
    #1;
    chk("reset_mscratch", bus.csr_rdata, 32'h0);

    // reset held, then release for 5 cycles
    bus.csr_raddr = 12'hB00;
    rst_n = 1'b1;
    repeat (5) tick();
    #1;
    chk("mcycle_after_5", bus.csr_rdata, 32'd5);

    // rollover from low to high half
    tick();
    csr_wr(12'hB00, 32'hFFFF_FFFF);
    tick();
    bus.csr_wenable = 1'b0;
    #1;
    chk("mcycle_loaded", bus.csr_rdata, 32'hFFFF_FFFF);
    tick();
    #1;
    chk("mcycle_wrap", bus.csr_rdata, 32'h0);
    bus.csr_raddr = 12'hB80;
    #1;
    chk("mcycleh_carry", bus.csr_rdata, 32'h1);

    // ALU examples
    alu_set(32'h7FFF_FFFF, 32'h1, 4'b0000);
    #1;
    chk("add_ovf", bus.alu_result, 32'h8000_0000);
    alu_set(32'h7FFF_FFFF, 32'h1, 4'b1000);
    #1;
    chk("sub_res", bus.alu_result, 32'h7FFF_FFFE);
    chk("sub_flags", {29'h0, bus.alu_lt, bus.alu_borrow, bus.alu_zero},
        32'h0);
    alu_set(32'hFFFF_FFFF, 32'h1, 4'b1000);
    #1;
    chk("neg_lt_borrow", {30'h0, bus.alu_lt, bus.alu_borrow}, 32'h2);
    alu_set(32'h8000_0000, 32'h4, 4'b1101);
    #1;
    chk("sra", bus.alu_result, 32'hF800_0000);
    alu_set(32'h8000_0000, 32'h4, 4'b0101);
    #1;
    chk("srl", bus.alu_result, 32'h0800_0000);
    alu_set(32'h1234_5678, 32'h1234_5678, 4'b1111);
    #1;
    chk("undef_op_zero", {bus.alu_result[30:0], bus.alu_zero},
        32'h1);

    // extender examples
    bus.ext_data = 32'h0000_80F0;
    bus.ext_control = 3'b000; #1;
    chk("lb", bus.ext_data_out, 32'hFFFF_FFF0);
    bus.ext_control = 3'b100; #1;
    chk("lbu", bus.ext_data_out, 32'h0000_00F0);
    bus.ext_control = 3'b001; #1;
    chk("lh", bus.ext_data_out, 32'hFFFF_80F0);
    bus.ext_control = 3'b101; #1;
    chk("lhu", bus.ext_data_out, 32'h0000_80F0);

    // mscratch write with same-cycle read
    tick();
    bus.csr_raddr = 12'h340;
    csr_wr(12'h340, 32'hDEAD_BEEF);
    #1;
    chk("same_cycle_old", bus.csr_rdata, 32'h0);
    tick();
    bus.csr_wenable = 1'b0;
    #1;
    chk("mscratch_new", bus.csr_rdata, 32'hDEAD_BEEF);
    csr_wr(12'h341, 32'h3);
    tick();
    csr_wr(12'h301, 32'h0);
    bus.csr_raddr = 12'h341;
    #1;
    chk("mepc_low_bits", bus.csr_rdata, 32'h0);
    tick();
    bus.csr_wenable = 1'b0;
    bus.csr_raddr = 12'h301;
    #1;
    chk("misa_ro", bus.csr_rdata, MISA);
    bus.csr_raddr = 12'hF14;
    #1;
    chk("mhartid", bus.csr_rdata, HART);

    // reset clears mscratch, write in reset cycle ignored
    rst_n = 1'b0;
    csr_wr(12'h340, 32'h1111_2222);
    tick();
    rst_n = 1'b1;
    bus.csr_wenable = 1'b0;
    bus.csr_raddr = 12'h340;
    #1;
    chk("mscratch_reset", bus.csr_rdata, 32'h0);
    bus.csr_raddr = 12'h7C0;
    #1;
    chk("unimpl_read", bus.csr_rdata, 32'h0);

    // random phase
    for (int n = 0; n < 3000; n++) begin
      tick();
      alu_set(rnd32(), rnd32(), 4'($urandom_range(0, 15)));
      bus.ext_data    = rnd32();
      bus.ext_control = 3'($urandom_range(0, 7));
      bus.csr_raddr   = addrs[$urandom_range(0, 14)];
      bus.csr_waddr   = addrs[$urandom_range(0, 14)];
      bus.csr_wdata   = rnd32();
      bus.csr_wenable = ($urandom_range(0, 2) == 0);
      rst_n = ($urandom_range(0, 63) != 0);
    end
    tick();
    @(posedge clk);
    #2;
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
